// File: rtl/mult_block_buffer.sv
// mult_block_buffer: multiplies operand pairs into an external memory block,
// then streams the closed block back out through a 2-entry output FIFO.
module mult_block_buffer #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 6,
   parameter int SIGNED = 0,
   parameter int SHIFT  = 0,
   parameter int SAT    = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic              flush,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_re,
   output logic [ADDR_W-1:0] mem_raddr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              rd_start,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic [ADDR_W:0]   blk_len,
   output logic              full
);
   typedef enum logic [1:0] {IDLE, FILL, FULL, DRAIN} state_t;
   localparam int PW = 2*DATA_W + 2;
   localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;
   localparam logic signed [PW-1:0] HI = SIGNED != 0 ? {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}}
                                                     : {{(PW-DATA_W){1'b0}}, {DATA_W{1'b1}}};
   localparam logic signed [PW-1:0] LO = SIGNED != 0 ? {{(PW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}} : '0;
   state_t state;
   logic [ADDR_W:0] count, rptr, opop, cnt_n;
   logic [1:0] fcnt;
   logic rv, acc, pop, close;
   logic [DATA_W-1:0] f0, f1, res;
   logic signed [DATA_W:0] ea, eb;
   logic signed [PW-1:0] prod, shp;
   // one extra sign bit lets a single signed multiplier serve both modes
   assign ea = {SIGNED != 0 && in_a[DATA_W-1], in_a};
   assign eb = {SIGNED != 0 && in_b[DATA_W-1], in_b};
   assign prod = PW'(ea) * PW'(eb);
   assign shp = prod >>> SHIFT;
   assign res = SAT != 0 && shp > HI ? HI[DATA_W-1:0] :
                SAT != 0 && shp < LO ? LO[DATA_W-1:0] : shp[DATA_W-1:0];
   assign in_ready = !rst && (state == IDLE || state == FILL) && count < DEPTH;
   assign full = state == FULL;
   assign blk_len = count;
   assign acc = in_valid && in_ready;
   assign cnt_n = count + (ADDR_W+1)'(acc);
   assign close = cnt_n == DEPTH || (flush && cnt_n != '0);
   assign out_valid = fcnt != 2'd0;
   assign out_data = out_valid ? f0 : '0;
   assign out_last = out_valid && opop == count - (ADDR_W+1)'(1);
   assign pop = out_valid && out_ready;
   // a read is issued only if its word is guaranteed a FIFO slot, counting the word leaving this cycle
   assign mem_re = state == DRAIN && rptr < count && {1'b0, fcnt} + {2'b0, rv} < 3'd2 + {2'b0, pop};
   assign mem_raddr = rptr[ADDR_W-1:0];
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         count <= '0;
         rptr <= '0;
         opop <= '0;
         fcnt <= '0;
         rv <= 1'b0;
         f0 <= '0;
         f1 <= '0;
         mem_we <= 1'b0;
         mem_waddr <= '0;
         mem_wdata <= '0;
      end else begin
         mem_we <= acc;
         if (acc) begin
            mem_waddr <= count[ADDR_W-1:0];
            mem_wdata <= res;
         end
         count <= cnt_n;
         rv <= mem_re;
         if (mem_re) rptr <= rptr + 1'b1;
         if (pop) opop <= opop + 1'b1;
         fcnt <= fcnt + {1'b0, rv} - {1'b0, pop};
         if (pop) f0 <= fcnt == 2'd1 ? mem_rdata : f1;
         else if (rv && fcnt == 2'd0) f0 <= mem_rdata;
         if (rv && fcnt == (pop ? 2'd2 : 2'd1)) f1 <= mem_rdata;
         case (state)
            IDLE, FILL: state <= close ? FULL : acc ? FILL : state;
            FULL: if (rd_start) state <= DRAIN;
            DRAIN: if (pop && out_last) begin
               state <= IDLE;
               count <= '0;
               rptr <= '0;
               opop <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mult_block_buffer.sv
// tb_mult_block_buffer: scoreboard bench for mult_block_buffer with a behavioural
// memory, plus three signed-arithmetic variants checked on their write port.
module tb_mult_block_buffer;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst = 1'b1, in_valid = 1'b0, flush = 1'b0, rd_start = 1'b0, out_ready = 1'b1;
   logic [15:0] in_a = '0, in_b = '0, mem_rdata;
   logic in_ready, mem_we, mem_re, out_valid, out_last, full;
   logic [5:0] mem_waddr, mem_raddr;
   logic [15:0] mem_wdata, out_data;
   logic [6:0] blk_len;
   logic [15:0] mem [64];
   int n_tests = 0, n_fail = 0, n_re = 0, re_base;
   logic [21:0] wq [$];
   logic [16:0] oq [$];
   logic [15:0] xq [3][$];
   logic stall = 1'b0;
   logic [15:0] held = '0;
   logic [3:0] pat = 4'b1001;
   mult_block_buffer u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .flush(flush), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .rd_start(rd_start),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .blk_len(blk_len), .full(full)
   );
   always @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_raddr];
   end
   // signed variants: 0 = SAT, 1 = wrap, 2 = Q8 (SHIFT 8, wrap)
   logic av = 1'b0;
   logic [15:0] aa = '0, ab = '0;
   logic [2:0] x_rdy, x_we, x_re, x_ov, x_ol, x_full;
   logic [5:0] x_wa [3], x_ra [3];
   logic [15:0] x_wd [3], x_od [3];
   logic [6:0] x_len [3];
   for (genvar g = 0; g < 3; g++) begin : g_x
      mult_block_buffer #(.SIGNED(1), .SAT(g == 0 ? 1 : 0), .SHIFT(g == 2 ? 8 : 0)) u_x (
         .clk(clk), .rst(rst), .in_valid(av), .in_ready(x_rdy[g]), .in_a(aa), .in_b(ab),
         .flush(1'b0), .mem_we(x_we[g]), .mem_waddr(x_wa[g]), .mem_wdata(x_wd[g]),
         .mem_re(x_re[g]), .mem_raddr(x_ra[g]), .mem_rdata(16'h0000), .rd_start(1'b0),
         .out_valid(x_ov[g]), .out_ready(1'b1), .out_data(x_od[g]), .out_last(x_ol[g]),
         .blk_len(x_len[g]), .full(x_full[g])
      );
   end
   logic [15:0] va [5] = '{16'h7FFF, 16'h8000, 16'h0100, 16'hFFFF, 16'h0200};
   logic [15:0] vb [5] = '{16'h0002, 16'h0002, 16'hFF00, 16'hFFFF, 16'h0300};
   logic [15:0] ex [3][5] = '{'{16'h7FFF, 16'h8000, 16'h8000, 16'h0001, 16'h7FFF},
                              '{16'hFFFE, 16'h0000, 16'h0000, 16'h0001, 16'h0000},
                              '{16'h00FF, 16'hFF00, 16'hFF00, 16'h0000, 16'h0600}};
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic put(input int addr, input int a, input int b, input bit fl);
      in_valid = 1'b1;
      in_a = 16'(a);
      in_b = 16'(b);
      flush = fl;
      wq.push_back({6'(addr), 16'(a * b)});
      step();
      in_valid = 1'b0;
      flush = 1'b0;
   endtask
   task automatic start_rd();
      rd_start = 1'b1;
      step();
      rd_start = 1'b0;
   endtask
   task automatic wait_out(input bit bp);
      for (int k = 0; k < 400 && oq.size() != 0; k++) begin
         out_ready = bp ? pat[k % 4] : 1'b1;
         step();
      end
      out_ready = 1'b1;
      if (oq.size() != 0) chk("drain_timeout", 64'(oq.size()), 0);
   endtask
   always @(negedge clk) begin
      if (mem_we) begin
         if (wq.size() == 0) chk("wr_unexpected", {mem_waddr, mem_wdata}, 64'hDEAD);
         else chk("wr", {mem_waddr, mem_wdata}, 64'(wq.pop_front()));
      end
      if (out_valid && out_ready) begin
         if (oq.size() == 0) chk("out_unexpected", {out_last, out_data}, 64'hDEAD);
         else chk("out", {out_last, out_data}, 64'(oq.pop_front()));
      end
      if (stall) chk("stall_hold", {out_valid, out_data}, {1'b1, held});
      for (int k = 0; k < 3; k++)
         if (x_we[k]) begin
            if (xq[k].size() == 0) chk("x_wr_unexpected", x_wd[k], 64'hDEAD);
            else chk($sformatf("x%0d_wr", k), x_wd[k], 64'(xq[k].pop_front()));
         end
      stall <= out_valid && !out_ready && !rst;
      held <= out_data;
      if (mem_re) n_re <= n_re + 1;
   end
   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end
   initial begin
      repeat (2) step();
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_outs", {mem_we, mem_re, mem_waddr, mem_raddr, mem_wdata, out_valid, out_data, out_last, blk_len, full}, 0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("in_ready_after_rst", in_ready, 1);
      step();
      for (int i = 0; i < 5; i++) begin
         av = 1'b1;
         aa = va[i];
         ab = vb[i];
         for (int k = 0; k < 3; k++) xq[k].push_back(ex[k][i]);
         step();
      end
      av = 1'b0;
      step();
      for (int i = 0; i < 64; i++) put(i, i, 3, 1'b0);
      @(negedge clk);
      chk("full_after_64", {in_ready, full, blk_len}, {1'b0, 1'b1, 7'd64});
      step();
      in_valid = 1'b1;
      in_a = 16'd5;
      in_b = 16'd5;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 64; i++) oq.push_back({i == 63, 16'(3 * i)});
      re_base = n_re;
      start_rd();
      @(negedge clk);
      chk("rd_lat_re", {mem_re, mem_raddr}, {1'b1, 6'd0});
      @(negedge clk);
      chk("rd_lat_c2", out_valid, 0);
      @(negedge clk);
      chk("rd_lat_c3", {out_valid, out_data}, {1'b1, 16'd0});
      wait_out(1'b0);
      step();
      @(negedge clk);
      chk("reads_64", 64'(n_re - re_base), 64);
      chk("idle_after_drain", {in_ready, full, blk_len}, {1'b1, 1'b0, 7'd0});
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      @(negedge clk);
      chk("flush_idle", {in_ready, full, blk_len}, {1'b1, 1'b0, 7'd0});
      step();
      start_rd();
      @(negedge clk);
      chk("rd_start_idle", {mem_re, out_valid, full}, 0);
      step();
      for (int i = 0; i < 6; i++) put(i, i + 1, 2, i == 5);
      @(negedge clk);
      chk("flush_close", {full, in_ready, blk_len}, {1'b1, 1'b0, 7'd6});
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      @(negedge clk);
      chk("flush_in_full", {full, blk_len}, {1'b1, 7'd6});
      step();
      for (int i = 0; i < 6; i++) oq.push_back({i == 5, 16'(2 * (i + 1))});
      re_base = n_re;
      start_rd();
      wait_out(1'b1);
      step();
      @(negedge clk);
      chk("reads_6_bp", 64'(n_re - re_base), 6);
      step();
      for (int i = 0; i < 16; i++) put(i, i, 7, i == 15);
      for (int i = 0; i < 16; i++) oq.push_back({i == 15, 16'(7 * i)});
      start_rd();
      for (int k = 0; k < 200 && oq.size() > 6; k++) step();
      chk("ten_words_out", 64'(oq.size()), 6);
      out_ready = 1'b0;
      rst = 1'b1;
      oq.delete();
      @(negedge clk);
      chk("rst_in_ready_drain", in_ready, 0);
      step();
      @(negedge clk);
      chk("rst_mid_drain", {in_ready, mem_we, mem_re, mem_waddr, mem_raddr, mem_wdata, out_valid, out_data, out_last, blk_len, full}, 0);
      step();
      rst = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("ready_after_rst2", {in_ready, blk_len}, {1'b1, 7'd0});
      step();
      put(0, 7, 5, 1'b0);
      put(1, 9, 4, 1'b1);
      oq.push_back({1'b0, 16'd35});
      oq.push_back({1'b1, 16'd36});
      start_rd();
      wait_out(1'b0);
      repeat (3) step();
      chk("scoreboard_empty", 64'(wq.size() + oq.size() + xq[0].size() + xq[1].size() + xq[2].size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
